// File: rtl/modexp_ctrl_pkg.sv
// modexp_ctrl_pkg: shared state encoding and default widths for the modexp controller
package modexp_ctrl_pkg;
   localparam int N_WIDTH_DEF   = 6;
   localparam int NUM_WIDTH_DEF = 12;
   localparam int EXP_WIDTH_DEF = 12;
   typedef enum logic [2:0] {
      IDLE, RB_ISSUE, RB_WAIT, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, DONE
   } state_e;
endpackage

// File: rtl/modexp_ctrl_modmul_step.sv
// modmul_step: selects the multiplier operands per issue state and forms the lookup dividend
module modmul_step
   import modexp_ctrl_pkg::*;
#(
   parameter int N_width   = N_WIDTH_DEF,
   parameter int num_width = NUM_WIDTH_DEF
) (
   input  state_e               state,
   input  logic [N_width-1:0]   base,
   input  logic [N_width-1:0]   base_r,
   input  logic [N_width-1:0]   acc,
   output logic [num_width-1:0] lut_num
);
   logic [num_width-1:0] a, b;
   // base reduction reuses the multiplier as base*1; non-issue states multiply by 0
   always_comb begin
      a = num_width'(state == RB_ISSUE ? base : acc);
      b = state == RB_ISSUE  ? num_width'(1) :
          state == SQ_ISSUE  ? num_width'(acc) :
          state == MUL_ISSUE ? num_width'(base_r) : '0;
      lut_num = a * b;
   end
endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply using an external registered modulo lookup
module modexp_ctrl
   import modexp_ctrl_pkg::*;
#(
   parameter int N_width   = N_WIDTH_DEF,
   parameter int num_width = NUM_WIDTH_DEF,
   parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [N_width-1:0]   base,
   input  logic [EXP_WIDTH-1:0] exp,
   input  logic [N_width-1:0]   N,
   output logic                 busy,
   output logic                 done,
   output logic [N_width-1:0]   result,
   output logic [num_width-1:0] lut_num,
   output logic [N_width-1:0]   lut_N,
   input  logic [N_width-1:0]   lut_out
);
   localparam int IW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;
   state_e               state_q, state_d, step_state;
   logic [N_width-1:0]   base_q, base_d, n_q, n_d, base_r_q, base_r_d;
   logic [N_width-1:0]   acc_q, acc_d, result_q, result_d;
   logic [EXP_WIDTH-1:0] exp_q, exp_d;
   logic [IW-1:0]        idx_q, idx_d, step_idx;
   logic                 busy_q, busy_d, done_q, done_d;

   modmul_step #(.N_width(N_width), .num_width(num_width)) u_step (
      .state(state_q), .base(base_q), .base_r(base_r_q), .acc(acc_q), .lut_num(lut_num)
   );

   assign lut_N  = state_q inside {RB_ISSUE, SQ_ISSUE, MUL_ISSUE} ? n_q : '0;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

   always_comb begin
      step_state = idx_q == '0 ? DONE : SQ_ISSUE;
      step_idx   = idx_q == '0 ? idx_q : idx_q - IW'(1);
      state_d    = state_q;
      base_d     = base_q;
      exp_d      = exp_q;
      n_d        = n_q;
      base_r_d   = base_r_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = RB_ISSUE;
            base_d  = base;
            exp_d   = exp;
            n_d     = N;
            acc_d   = N_width'(1);
            idx_d   = IW'(EXP_WIDTH - 1);
         end
         RB_ISSUE:  state_d = RB_WAIT;
         RB_WAIT: begin
            base_r_d = lut_out;
            state_d  = SQ_ISSUE;
         end
         SQ_ISSUE:  state_d = SQ_WAIT;
         SQ_WAIT: begin
            acc_d   = lut_out;
            state_d = exp_q[idx_q] ? MUL_ISSUE : step_state;
            idx_d   = exp_q[idx_q] ? idx_q : step_idx;
         end
         MUL_ISSUE: state_d = MUL_WAIT;
         MUL_WAIT: begin
            acc_d   = lut_out;
            state_d = step_state;
            idx_d   = step_idx;
         end
         default:   state_d = IDLE;
      endcase
      result_d = state_d == DONE ? acc_d : result_q;
      busy_d   = !(state_d inside {IDLE, DONE});
      done_d   = state_d == DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         base_q   <= '0;
         exp_q    <= '0;
         n_q      <= '0;
         base_r_q <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         n_q      <= n_d;
         base_r_q <= base_r_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: directed scoreboard bench for modexp_ctrl with a behavioural modulo BRAM
module tb_modexp_ctrl;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [5:0]  base, N, result, lut_N, lut_out;
   logic [11:0] exp, lut_num;
   logic        busy, done;
   int          checks = 0, failures = 0;

   typedef struct {logic [5:0] res; int lat;} exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   modexp_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .N(N),
      .busy(busy), .done(done), .result(result),
      .lut_num(lut_num), .lut_N(lut_N), .lut_out(lut_out)
   );

   // 6/12 modulo table: registered remainder, zero for a zero divisor
   always_ff @(posedge clk)
      lut_out <= lut_N == 6'd0 ? 6'd0 : 6'(lut_num % 12'(lut_N));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // called on a negedge; start is sampled at the following posedge (cycle 0)
   task automatic run(input logic [5:0] b, input logic [11:0] e, input logic [5:0] n,
                      input logic [5:0] res, input bit disturb);
      exp_t x;
      int   cyc;
      logic [5:0] held;
      sb.push_back('{res: res, lat: 3 + 2 * 12 + 2 * $countones(e)});
      start = 1'b1; base = b; exp = e; N = n;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 1;
      @(negedge clk);
      chk("rb_lut_num", lut_num, {6'd0, b});
      chk("rb_lut_N", lut_N, n);
      chk("busy_running", busy, 1);
      while (!done && cyc < 200) begin
         start = 1'b0;
         if (disturb && cyc == 5) begin
            start = 1'b1; base = 6'd9; exp = 12'd7; N = 6'd29;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_seen", done, 1);
      x = sb.pop_front();
      chk("result", result, x.res);
      chk("latency", cyc, x.lat);
      chk("busy_in_done", busy, 0);
      held = result;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("result_hold", result, held);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; start = 1'b0; base = '0; exp = '0; N = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_lut_num", lut_num, 0);
      chk("rst_lut_N", lut_N, 0);
      rst = 1'b0;
      @(negedge clk);
      run(6'd5,  12'd3,  6'd13, 6'd8,  1'b0);
      run(6'd4,  12'd13, 6'd61, 6'd19, 1'b0);
      run(6'd63, 12'd1,  6'd10, 6'd3,  1'b0);
      run(6'd7,  12'd0,  6'd1,  6'd0,  1'b0);
      run(6'd7,  12'd0,  6'd0,  6'd0,  1'b0);
      run(6'd7,  12'd0,  6'd5,  6'd1,  1'b0);
      run(6'd5,  12'd3,  6'd13, 6'd8,  1'b1);
      start = 1'b1; base = 6'd4; exp = 12'd13; N = 6'd61;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 0);
      chk("abort_lut_N", lut_N, 0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= done;
      end
      chk("abort_no_done", seen, 0);
      run(6'd2, 12'd10, 6'd31, 6'd1, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
